// File: rtl/scr1_xor_trace_buf.sv
// scr1_xor_trace_buf: captures {pc, mstatus, mcycle} for every XOR instruction
// seen on the IFU-to-IDU path into a small ring buffer and streams each record
// out as four XLEN-wide beats over a valid/ready port.
module scr1_xor_trace_buf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_vld,
  input  logic [31:0]              instr,
  input  logic [XLEN-1:0]          pc,
  input  logic [XLEN-1:0]          csr_mstatus,
  input  logic [CNT_W-1:0]         csr_mcycle,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [XLEN-1:0]          out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt,
  input  logic                     drop_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Record storage; contents are only meaningful between head and tail.
  logic [XLEN-1:0]  pc_mem_q [DEPTH];
  logic [XLEN-1:0]  ms_mem_q [DEPTH];
  logic [CNT_W-1:0] mc_mem_q [DEPTH];

  state_e          state_q,    state_d;
  logic [AW-1:0]   head_q,     head_d;
  logic [AW-1:0]   tail_q,     tail_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [1:0]      beat_q,     beat_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            out_vld_q,  out_vld_d;
  logic            out_last_q, out_last_d;
  logic [XLEN-1:0] out_data_q, out_data_d;

  logic det_c;
  logic hs_c;
  logic pop_c;
  logic wr_c;
  logic drop_c;
  logic sel_new_c;
  logic unused_instr_c;

  // Picks one of the four beats out of a record.
  function automatic logic [XLEN-1:0] beat_sel(input logic [1:0]       b,
                                               input logic [XLEN-1:0]  p,
                                               input logic [XLEN-1:0]  m,
                                               input logic [CNT_W-1:0] c);
    logic [XLEN-1:0] r;
    case (b)
      2'd0:    r = p;
      2'd1:    r = m;
      2'd2:    r = c[XLEN-1:0];
      default: r = c[CNT_W-1:XLEN];
    endcase
    return r;
  endfunction

  // Register/immediate fields play no part in XOR detection.
  assign unused_instr_c = ^{instr[24:15], instr[11:7]};

  // Next-state: detection, pointer/count bookkeeping, FSM and output beat.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    beat_d     = beat_q;
    drop_cnt_d = drop_cnt_q;

    det_c  = instr_vld && (instr[6:0] == 7'b0110011) &&
             (instr[14:12] == 3'b100) && (instr[31:25] == 7'b0000000);
    hs_c   = out_vld_q && out_rdy;
    pop_c  = hs_c && (beat_q == 2'd3);
    // Fullness is judged on the pre-pop count: a same-cycle pop never frees a slot.
    wr_c   = det_c && (count_q != CW'(DEPTH));
    drop_c = det_c && (count_q == CW'(DEPTH));

    if (wr_c)  tail_d = AW'(tail_q + AW'(1));
    if (pop_c) head_d = AW'(head_q + AW'(1));
    if (hs_c)  beat_d = 2'(beat_q + 2'd1);

    case ({wr_c, pop_c})
      2'b10:   count_d = CW'(count_q + CW'(1));
      2'b01:   count_d = CW'(count_q - CW'(1));
      default: count_d = count_q;
    endcase

    if (drop_clr)                          drop_cnt_d = 8'h00;
    else if (drop_c && drop_cnt_q != 8'hFF) drop_cnt_d = 8'(drop_cnt_q + 8'd1);

    case (state_q)
      IDLE:    if (count_d != '0) state_d = SEND;
      SEND:    if (pop_c && count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    out_vld_d  = (state_d == SEND);
    out_last_d = (state_d == SEND) && (beat_d == 2'd3);

    // When the buffer is empty after this cycle's pop, the next head is the slot
    // being written right now, so its first beat comes straight from the write data.
    sel_new_c = wr_c && (count_q == CW'(pop_c));
    if (sel_new_c)
      out_data_d = beat_sel(beat_d, pc, csr_mstatus, csr_mcycle);
    else
      out_data_d = beat_sel(beat_d, pc_mem_q[head_d], ms_mem_q[head_d], mc_mem_q[head_d]);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      drop_cnt_q <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      drop_cnt_q <= drop_cnt_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_data_q <= out_data_d;
    end
  end

  // Record storage write at the tail slot.
  always_ff @(posedge clk) begin
    if (!rst && wr_c) begin
      pc_mem_q[tail_q] <= pc;
      ms_mem_q[tail_q] <= csr_mstatus;
      mc_mem_q[tail_q] <= csr_mcycle;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_last = out_last_q;
  assign out_data = out_data_q;
  assign count    = count_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_scr1_xor_trace_buf.sv
// Directed bench for scr1_xor_trace_buf (DEPTH=4, XLEN=32, CNT_W=64).
module tb_scr1_xor_trace_buf;

  localparam logic [31:0] XOR_W = 32'h00C5C533;
  localparam logic [31:0] OR_W  = 32'h00C5E533;
  localparam logic [31:0] SUB_W = 32'h40C5C533;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_vld;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] csr_mstatus;
  logic [63:0] csr_mcycle;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_data;
  logic        out_last;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;
  logic        drop_clr;

  int errs   = 0;
  int checks = 0;

  scr1_xor_trace_buf #(.DEPTH(4), .XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .instr_vld(instr_vld), .instr(instr), .pc(pc),
    .csr_mstatus(csr_mstatus), .csr_mcycle(csr_mcycle), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
    .count(count), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p,
                       input logic [31:0] m, input logic [63:0] c);
    instr_vld   = v;
    instr       = w;
    pc          = p;
    csr_mstatus = m;
    csr_mcycle  = c;
  endtask

  task automatic idle_in();
    drive(1'b0, 32'h0000_0013, 32'h0, 32'h0, 64'h0);
  endtask

  task automatic beat(input string tag, input logic [31:0] d, input logic last);
    chk({tag, "_vld"},  64'(out_vld),  64'd1);
    chk({tag, "_data"}, 64'(out_data), 64'(d));
    chk({tag, "_last"}, 64'(out_last), 64'(last));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; out_rdy = 1'b0; drop_clr = 1'b0;
    idle_in();
    do_reset();

    // Reset state
    chk("rst_vld",   64'(out_vld),  64'd0);
    chk("rst_last",  64'(out_last), 64'd0);
    chk("rst_count", 64'(count),    64'd0);
    chk("rst_drop",  64'(drop_cnt), 64'd0);

    // Single XOR, consumer always ready
    out_rdy = 1'b1;
    drive(1'b1, XOR_W, 32'h100, 32'h1800, 64'h5_0000_0010);
    tick();
    idle_in();
    chk("s_count1", 64'(count), 64'd1);
    beat("s_b0", 32'h100, 1'b0);  tick();
    beat("s_b1", 32'h1800, 1'b0); tick();
    beat("s_b2", 32'h10, 1'b0);   tick();
    beat("s_b3", 32'h5, 1'b1);    tick();
    chk("s_done_vld",   64'(out_vld), 64'd0);
    chk("s_done_count", 64'(count),   64'd0);

    // Lookalikes never record
    drive(1'b1, OR_W,  32'h200, 32'h1, 64'h1);  tick();
    drive(1'b1, SUB_W, 32'h204, 32'h1, 64'h1);  tick();
    drive(1'b0, XOR_W, 32'h208, 32'h1, 64'h1);  tick();
    idle_in(); tick();
    chk("look_count", 64'(count),   64'd0);
    chk("look_vld",   64'(out_vld), 64'd0);

    // Five back-to-back XORs with consumer stalled: fifth is dropped
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, XOR_W, 32'h1000 + i, 32'h2000 + i, {32'hA0 + 32'(i), 32'hB0 + 32'(i)});
      tick();
    end
    idle_in();
    chk("ovf_count", 64'(count),    64'd4);
    chk("ovf_drop",  64'(drop_cnt), 64'd1);
    chk("ovf_hold",  64'(out_data), 64'h1000);
    out_rdy = 1'b1;
    for (int r = 0; r < 4; r++) begin
      beat("ovf_p",  32'h1000 + 32'(r), 1'b0); tick();
      beat("ovf_m",  32'h2000 + 32'(r), 1'b0); tick();
      beat("ovf_cl", 32'hB0 + 32'(r),   1'b0); tick();
      beat("ovf_ch", 32'hA0 + 32'(r),   1'b1); tick();
    end
    chk("ovf_end_vld",   64'(out_vld), 64'd0);
    chk("ovf_end_count", 64'(count),   64'd0);

    // Ready toggling 1,0,0,1 during SEND
    drive(1'b1, XOR_W, 32'hABC, 32'hDEF, 64'h7_0000_0009);
    tick();
    idle_in();
    beat("tg_b0", 32'hABC, 1'b0);
    out_rdy = 1'b1; tick();
    beat("tg_b1", 32'hDEF, 1'b0);
    out_rdy = 1'b0; tick();
    beat("tg_h1", 32'hDEF, 1'b0);
    tick();
    beat("tg_h2", 32'hDEF, 1'b0);
    out_rdy = 1'b1; tick();
    beat("tg_b2", 32'h9, 1'b0); tick();
    beat("tg_b3", 32'h7, 1'b1); tick();
    chk("tg_end_vld", 64'(out_vld), 64'd0);

    // Full buffer, detection coincides with beat3 handshake
    drop_clr = 1'b1; tick(); drop_clr = 1'b0;
    chk("clr_drop", 64'(drop_cnt), 64'd0);
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, XOR_W, 32'h40 + 32'(i), 32'h50 + 32'(i), {32'h60 + 32'(i), 32'h70 + 32'(i)});
      tick();
    end
    idle_in();
    out_rdy = 1'b1;
    tick(); tick(); tick();
    beat("fp_b3", 32'h60, 1'b1);
    drive(1'b1, XOR_W, 32'h99, 32'h99, 64'h99);
    tick();
    idle_in();
    chk("fp_count", 64'(count),    64'd3);
    chk("fp_drop",  64'(drop_cnt), 64'd1);
    for (int r = 1; r < 4; r++) begin
      beat("fp_p",  32'h40 + 32'(r), 1'b0); tick();
      beat("fp_m",  32'h50 + 32'(r), 1'b0); tick();
      beat("fp_cl", 32'h70 + 32'(r), 1'b0); tick();
      beat("fp_ch", 32'h60 + 32'(r), 1'b1); tick();
    end
    chk("fp_end_vld", 64'(out_vld), 64'd0);

    // Drop counter saturation and clear-over-increment priority
    out_rdy = 1'b0;
    drive(1'b1, XOR_W, 32'h1, 32'h2, 64'h3);
    for (int i = 0; i < 265; i++) tick();
    chk("sat_count", 64'(count),    64'd4);
    chk("sat_drop",  64'(drop_cnt), 64'hFF);
    drop_clr = 1'b1; tick(); drop_clr = 1'b0;
    chk("sat_clr", 64'(drop_cnt), 64'd0);
    idle_in();
    do_reset();

    // Reset during beat2 with two records stored
    drive(1'b1, XOR_W, 32'h500, 32'h501, 64'h503_0000_0502); tick();
    drive(1'b1, XOR_W, 32'h600, 32'h601, 64'h603_0000_0602); tick();
    idle_in();
    out_rdy = 1'b1;
    tick(); tick();
    beat("mr_b2", 32'h502, 1'b0);
    rst = 1'b1;
    drive(1'b1, XOR_W, 32'h777, 32'h777, 64'h777);
    tick();
    rst = 1'b0;
    idle_in();
    chk("mr_vld",   64'(out_vld),  64'd0);
    chk("mr_last",  64'(out_last), 64'd0);
    chk("mr_count", 64'(count),    64'd0);
    chk("mr_drop",  64'(drop_cnt), 64'd0);
    drive(1'b1, XOR_W, 32'h700, 32'h701, 64'h703_0000_0702); tick();
    idle_in();
    chk("mr_count1", 64'(count), 64'd1);
    beat("mr_n0", 32'h700, 1'b0); tick();
    beat("mr_n1", 32'h701, 1'b0); tick();
    beat("mr_n2", 32'h702, 1'b0); tick();
    beat("mr_n3", 32'h703, 1'b1); tick();
    chk("mr_end_vld",   64'(out_vld), 64'd0);
    chk("mr_end_count", 64'(count),   64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/scr1_xor_trace_buf.md
SCR1_XOR_TRACE_BUF -- requirements
Module: scr1_xor_trace_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of buffered trace records (power of two, min 2).
REQ-002 SHALL have parameter XLEN, default 32: width of pc, mstatus and output beat.
REQ-003 SHALL have parameter CNT_W, default 64: mcycle width (2*XLEN).
REQ-004 SHALL have port clk  input  1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port instr_vld  input  1: instr is a valid IFU-to-IDU instruction this cycle.
REQ-007 SHALL have port instr  input  32: instruction word.
REQ-008 SHALL have port pc  input  XLEN: pc of instr.
REQ-009 SHALL have port csr_mstatus  input  XLEN: current mstatus.
REQ-010 SHALL have port csr_mcycle  input  CNT_W: current mcycle.
REQ-011 SHALL have port out_vld  output  1: out_data holds a valid beat.
REQ-012 SHALL have port out_rdy  input  1: consumer accepts the beat.
REQ-013 SHALL have port out_data  output  XLEN: current beat of the head record.
REQ-014 SHALL have port out_last  output  1: current beat is beat 3 of the record.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1: records stored.
REQ-016 SHALL have port drop_cnt  output  8: saturating count of dropped records.
REQ-017 SHALL have port drop_clr  input  1: clears drop_cnt.

Function
REQ-018 SHALL detect XOR when instr_vld=1, instr[6:0]=7'b0110011, instr[14:12]=3'b100, instr[31:25]=7'b0000000; no other instruction triggers.
REQ-019 SHALL, on detection in cycle N with count<DEPTH, write {pc, csr_mstatus, csr_mcycle} sampled in cycle N into the tail slot at the end of cycle N.
REQ-020 SHALL, on detection when count=DEPTH (pre-pop value), drop the record even if a final beat is popped that cycle, and increment drop_cnt.
REQ-021 SHALL saturate drop_cnt at 8'hFF; drop_clr clears it to 0 and takes priority over a simultaneous increment.
REQ-022 SHALL serialise the head record as 4 beats: beat0 pc, beat1 mstatus, beat2 mcycle[XLEN-1:0], beat3 mcycle[CNT_W-1:XLEN].
REQ-023 SHALL implement FSM IDLE/SEND: IDLE->SEND when count>0 at end of cycle; SEND->IDLE after beat3 handshake when the resulting count=0; otherwise remains SEND starting beat0 of the next record.
REQ-024 SHALL assert out_vld exactly in SEND; earliest out_vld is cycle N+1 for a record written in cycle N from empty.
REQ-025 SHALL advance the beat index only on out_vld&out_rdy; out_data/out_last SHALL hold stable while out_vld=1 and out_rdy=0.
REQ-026 SHALL pop the head record (head pointer wraps modulo DEPTH) on the beat3 handshake; count decrements that cycle.
REQ-027 SHALL, on simultaneous accepted write and pop, leave count unchanged and advance both pointers.
REQ-028 SHALL drive out_data from registered storage only (no combinational path from instr/pc/CSR inputs to outputs).

Reset
REQ-029 SHALL, with rst=1 at a clock edge, set FSM=IDLE, head/tail/beat index=0, count=0, drop_cnt=0, out_vld=0, out_last=0; out_data value is don't-care while out_vld=0.
REQ-030 SHALL discard stored records and any partly-sent record on reset mid-transfer; a detection in the reset cycle SHALL be ignored.

Verification
REQ-031 Single XOR (instr=32'h00C5C533, pc=0x100, mstatus=0x1800, mcycle=0x5_0000_0010), out_rdy=1 -> beats 0x100,0x1800,0x10,0x5 on cycles N+1..N+4, out_last only on 4th, count back to 0.
REQ-032 Non-XOR lookalikes (funct3=3'b110 OR, funct7=7'b0100000, instr_vld=0 with XOR word) -> no record, count stays 0.
REQ-033 Five XORs back-to-back, out_rdy=0, DEPTH=4 -> count=4, drop_cnt=1; release out_rdy -> first four records emitted in order, 16 beats.
REQ-034 out_rdy toggling 1,0,0,1 during SEND -> out_data held while stalled, no beat skipped or duplicated.
REQ-035 Full buffer, XOR detected in same cycle as beat3 handshake -> record dropped, drop_cnt+1, count=3; drop_clr with drop at 0xFF -> drop_cnt=0.
REQ-036 rst=1 during beat2 of a record with 2 stored -> next cycle out_vld=0, count=0, drop_cnt=0; next XOR emits from beat0.
